// File: rtl/gol_generation_sequencer.sv
// Multi-generation run controller for the Game of Life core: one start/completed
// handshake per generation, ping-ponging between grid buffers A and B. Watchdog via GOL_SEQ_TIMEOUT_EN.
module gol_generation_sequencer #(
    parameter int ADDR_W         = 12,
    parameter int GEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_host_start,
    input  logic [GEN_W-1:0]  io_host_generations,
    input  logic [ADDR_W-1:0] io_buf_a_address,
    input  logic [ADDR_W-1:0] io_buf_b_address,
    output logic              io_core_start,
    input  logic              io_core_completed,
    output logic [ADDR_W-1:0] io_core_starting_address,
    output logic [ADDR_W-1:0] io_core_result_address,
    output logic              io_busy,
    output logic              io_done,
    output logic [GEN_W-1:0]  io_generation_count,
    output logic [ADDR_W-1:0] io_final_address,
    output logic              io_error
);

`ifdef GOL_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_RELEASE, S_DONE, S_ERROR
    } state_t;
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] tmo_q, tmo_d;
    logic        error_q, error_d;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_RELEASE, S_DONE
    } state_t;
`endif

    state_t            state_q, state_d;
    logic              prev_q, prev_d;
    logic [GEN_W-1:0]  gens_q, gens_d;
    logic [GEN_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] a_q, a_d, b_q, b_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d, raddr_q, raddr_d;
    logic [ADDR_W-1:0] final_q, final_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              host_edge;

    assign host_edge = io_host_start & ~prev_q;

    always_comb begin
        state_d = state_q;
        prev_d  = io_host_start;
        gens_d  = gens_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        saddr_d = saddr_q;
        raddr_d = raddr_q;
        final_d = final_q;
        start_d = start_q;
`ifdef GOL_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (host_edge) begin
                    gens_d  = io_host_generations;
                    a_d     = io_buf_a_address;
                    b_d     = io_buf_b_address;
                    count_d = '0;
                    final_d = io_buf_a_address;
                    saddr_d = io_buf_a_address;
                    raddr_d = io_buf_b_address;
                    state_d = (io_host_generations == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_d = 1'b1;
                state_d = S_RUN;
`ifdef GOL_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_RUN: begin
                if (io_core_completed) begin
                    start_d = 1'b0;
                    count_d = count_q + 1'b1;
                    final_d = raddr_q;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Equality stop: the count can never wrap, even at all-ones gens
                if (!io_core_completed) begin
                    if (count_q == gens_q) begin
                        state_d = S_DONE;
                    end else begin
                        saddr_d = count_q[0] ? b_q : a_q;
                        raddr_d = count_q[0] ? a_q : b_q;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                if (!io_host_start) state_d = S_IDLE;
            end
`ifdef GOL_SEQ_TIMEOUT_EN
            S_ERROR: begin
                if (!io_host_start) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef GOL_SEQ_TIMEOUT_EN
        if (state_q == S_RUN || state_q == S_RELEASE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_ERROR;
                start_d = 1'b0;
            end else begin
                tmo_d = tmo_q + 20'd1;
            end
        end
        error_d = (state_d == S_ERROR);
`endif
        busy_d = (state_d == S_LAUNCH) || (state_d == S_RUN) ||
                 (state_d == S_RELEASE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            prev_q  <= 1'b0;
            gens_q  <= '0;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            saddr_q <= '0;
            raddr_q <= '0;
            final_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GOL_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            gens_q  <= gens_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            saddr_q <= saddr_d;
            raddr_q <= raddr_d;
            final_q <= final_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GOL_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
            error_q <= error_d;
`endif
        end
    end

    assign io_core_start            = start_q;
    assign io_core_starting_address = saddr_q;
    assign io_core_result_address   = raddr_q;
    assign io_busy                  = busy_q;
    assign io_done                  = done_q;
    assign io_generation_count      = count_q;
    assign io_final_address         = final_q;
`ifdef GOL_SEQ_TIMEOUT_EN
    assign io_error                 = error_q;
`else
    assign io_error                 = 1'b0;
`endif

endmodule
